// File: rtl/band_mix_pkg.sv
// Shared types, constants and saturation helper for the band mixer.
package band_mix_pkg;

  localparam int unsigned NUM_BANDS_DEF = 16;
  localparam int unsigned GAIN_W_DEF    = 8;
  localparam int unsigned UNITY_GAIN    = 2 ** (GAIN_W_DEF - 1);

  // Width of a shifted accumulator: 16 + 1 + 1 + clog2(64) covers every legal configuration.
  localparam int unsigned SAT_IN_W = 24;
  localparam logic signed [SAT_IN_W-1:0] SAT_HI = SAT_IN_W'(32767);
  localparam logic signed [SAT_IN_W-1:0] SAT_LO = SAT_IN_W'(-32768);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  function automatic logic signed [15:0] sat16(input logic signed [SAT_IN_W-1:0] v);
    if (v > SAT_HI) begin
      sat16 = 16'sh7fff;
    end else if (v < SAT_LO) begin
      sat16 = 16'sh8000;
    end else begin
      sat16 = v[15:0];
    end
  endfunction

endpackage

// File: rtl/band_mac.sv
// Shared multiply-accumulate: signed sample times unsigned gain, summed into a wide register.
module band_mac #(
  parameter int unsigned GAIN_W = 8,
  parameter int unsigned ACC_W  = 29
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     en,
  input  logic signed [15:0]       sample,
  input  logic        [GAIN_W-1:0] gain,
  output logic signed [ACC_W-1:0]  acc
);

  localparam int unsigned PROD_W = 17 + GAIN_W;

  logic signed [PROD_W-1:0] prod;

  // Gain gets a zero sign bit so the product stays a plain signed multiply.
  assign prod = PROD_W'(sample) * PROD_W'($signed({1'b0, gain}));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/band_mixer.sv
// Gathers one sample per band, mixes them through a time-shared MAC and emits a saturated sum per frame.
module band_mixer
  import band_mix_pkg::*;
#(
  parameter int unsigned NUM_BANDS = NUM_BANDS_DEF,
  parameter int unsigned GAIN_W    = GAIN_W_DEF
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_BANDS-1:0][15:0]          band_data,
  input  logic [NUM_BANDS-1:0]                band_valid,
  input  logic [NUM_BANDS-1:0][GAIN_W-1:0]    band_gain,
  output logic signed [15:0]                  mix_out,
  output logic                                mix_valid,
  output logic                                busy,
  output logic                                overrun
);

  localparam int unsigned IDX_W = $clog2(NUM_BANDS);
  localparam int unsigned ACC_W = 16 + GAIN_W + 1 + $clog2(NUM_BANDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BANDS - 1);

  state_t state_q, state_d;

  logic [NUM_BANDS-1:0][15:0] sample_q;
  logic [NUM_BANDS-1:0][15:0] snap_q;
  logic [NUM_BANDS-1:0]       pending_q;
  logic [IDX_W-1:0]           idx_q;

  logic start;
  logic mac_en;
  logic out_en;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_shift;
  logic signed [15:0]      mix_sat;

  band_mac #(
    .GAIN_W (GAIN_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clear  (start),
    .en     (mac_en),
    .sample (snap_q[idx_q]),
    .gain   (band_gain[idx_q]),
    .acc    (acc)
  );

  assign acc_shift = acc >>> (GAIN_W - 1);
  assign mix_sat   = sat16(SAT_IN_W'(acc_shift));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    mac_en  = 1'b0;
    out_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (&pending_q) begin
          start   = 1'b1;
          state_d = MAC;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = OUT;
        end
      end
      OUT: begin
        out_en  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture, snapshot and output registers; a new strobe on a band wins over the snapshot clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_q  <= '0;
      snap_q    <= '0;
      pending_q <= '0;
      idx_q     <= '0;
      mix_out   <= '0;
      mix_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NUM_BANDS); i++) begin
        if (band_valid[i]) begin
          sample_q[i] <= band_data[i];
        end
      end
      pending_q <= (start ? '0 : pending_q) | band_valid;
      if (|(band_valid & pending_q) && !start) begin
        overrun <= 1'b1;
      end
      if (start) begin
        snap_q <= sample_q;
        idx_q  <= '0;
      end else if (mac_en) begin
        idx_q <= IDX_W'(idx_q + 1'b1);
      end
      if (out_en) begin
        mix_out <= mix_sat;
      end
      mix_valid <= out_en;
      busy      <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_band_mixer.sv
// Directed scoreboard bench for band_mixer: expected mixes are queued at issue time and checked by a monitor.
module tb_band_mixer;
  import band_mix_pkg::*;

  localparam int NB = 16;
  localparam int GW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NB-1:0][15:0]   band_data  = '0;
  logic [NB-1:0]         band_valid = '0;
  logic [NB-1:0][GW-1:0] band_gain  = '0;
  logic signed [15:0]    mix_out;
  logic                  mix_valid;
  logic                  busy;
  logic                  overrun;

  typedef struct {
    int val;
    int cyc;
    int id;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   frame[NB];

  band_mixer #(
    .NUM_BANDS (NB),
    .GAIN_W    (GW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .band_data  (band_data),
    .band_valid (band_valid),
    .band_gain  (band_gain),
    .mix_out    (mix_out),
    .mix_valid  (mix_valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: actual %0d required %0d", name, act, req);
  endtask

  task automatic expect_mix(input int val, input int at_cyc, input int id);
    exp_t e;
    e.val = val;
    e.cyc = at_cyc;
    e.id  = id;
    exp_q.push_back(e);
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < NB; i++) frame[i] = v;
  endtask

  task automatic set_gain(input int g);
    for (int i = 0; i < NB; i++) band_gain[i] = GW'(g);
  endtask

  // Drive one strobe cycle; c is the cycle in which band_valid is high.
  task automatic send(input logic [NB-1:0] mask, output int c);
    @(negedge clk);
    c = cyc;
    for (int i = 0; i < NB; i++) band_data[i] = 16'(frame[i]);
    band_valid = mask;
    @(negedge clk);
    band_valid = '0;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst && mix_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_mix: actual mix_out=%0d at cycle %0d, required no output", mix_out, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check($sformatf("mix_out_%0d", mon_e.id), int'(mix_out), mon_e.val);
        check($sformatf("latency_%0d", mon_e.id), cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    int c;
    int c2;

    repeat (2) @(negedge clk);
    check("rst_mix_out", int'(mix_out), 0);
    check("rst_mix_valid", int'(mix_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);
    rst = 1'b0;

    // Unity gain, 16 x 100
    set_gain(int'(UNITY_GAIN));
    fill(100);
    send('1, c);
    expect_mix(1600, c + 19, 1);
    @(negedge clk);
    check("busy_in_mac", int'(busy), 1);
    drain(40);
    check("busy_after_frame", int'(busy), 0);
    check("overrun_t1", int'(overrun), 0);

    // Saturation on both rails
    set_gain(255);
    fill(32767);
    send('1, c);
    expect_mix(32767, c + 19, 2);
    drain(40);
    fill(-32768);
    send('1, c);
    expect_mix(-32768, c + 19, 3);
    drain(40);

    // Arithmetic shift floors: -3 * 64 / 128 = -1.5 -> -2
    set_gain(0);
    band_gain[0] = GW'(64);
    fill(1000);
    frame[0] = -3;
    send('1, c);
    expect_mix(-2, c + 19, 4);
    drain(40);

    // Staggered completion: band 15 arrives five cycles late
    set_gain(int'(UNITY_GAIN));
    for (int i = 0; i < NB; i++) frame[i] = 10 * (i + 1);
    send(16'h7FFF, c);
    repeat (3) @(negedge clk);
    check("busy_partial_frame", int'(busy), 0);
    send(16'h8000, c2);
    expect_mix(1360, c + 24, 5);
    drain(40);

    // Back-to-back frames: second arrives during MAC of the first
    fill(50);
    send('1, c);
    expect_mix(800, c + 19, 6);
    repeat (3) @(negedge clk);
    fill(25);
    send('1, c2);
    expect_mix(400, c + 37, 7);
    drain(80);
    check("overrun_back_to_back", int'(overrun), 0);

    // Band 3 strobed twice before the frame completes
    fill(0);
    frame[3] = 7;
    send(16'h0008, c);
    check("overrun_first_strobe", int'(overrun), 0);
    frame[3] = 9;
    send(16'h0008, c);
    check("overrun_set", int'(overrun), 1);
    send(16'hFFF7, c);
    expect_mix(9, c + 19, 8);
    drain(40);
    check("overrun_sticky", int'(overrun), 1);

    // Reset in the middle of MAC (idx 7) with a partial frame pending
    fill(1000);
    send('1, c);
    repeat (3) @(negedge clk);
    fill(1);
    send(16'h00FF, c2);
    repeat (3) @(negedge clk);
    check("busy_before_abort", int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check("abort_mix_out", int'(mix_out), 0);
    check("abort_mix_valid", int'(mix_valid), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_overrun", int'(overrun), 0);
    @(negedge clk);
    rst = 1'b0;
    send(16'hFF00, c2);
    repeat (25) @(negedge clk);
    check("no_start_after_abort", int'(busy), 0);
    fill(3);
    send('1, c);
    expect_mix(48, c + 19, 9);
    drain(40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
